// File: rtl/fns_serial_decoder_pkg.sv
// Shared constants and FSM encoding for the FNS serial decoder (9-TSV link, 5 data + 4 redundant).
package fns_serial_decoder_pkg;
  localparam int N_TSV  = 9;
  localparam int N_DATA = 5;
  localparam int W_W    = 4;
  localparam int DATA_W = 5;
  localparam int IDX_W  = $clog2(N_TSV);
  localparam int CNT_W  = $clog2(N_DATA + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Fibonacci seeds: the first healthy TSV gets weight a+b = 1
  localparam logic [W_W-1:0] FIB_A0 = '0;
  localparam logic [W_W-1:0] FIB_B0 = W_W'(1);
endpackage

// File: rtl/fns_serial_decoder_if.sv
// Codeword-in / decoded-word-out handshake bundle for fns_serial_decoder (valid/ready on both sides).
// FNS_CAC_CHECK_EN adds the code_err result bit.
interface fns_serial_decoder_if;
  import fns_serial_decoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [N_TSV-1:0]  code;
  logic [N_TSV-1:0]  f_flag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data;
  logic [N_TSV-1:0]  en_flag;
  logic              short_err;
`ifdef FNS_CAC_CHECK_EN
  logic              code_err;

  modport master (
    output in_valid, code, f_flag, out_ready,
    input  in_ready, out_valid, data, en_flag, short_err, code_err
  );
  modport slave (
    input  in_valid, code, f_flag, out_ready,
    output in_ready, out_valid, data, en_flag, short_err, code_err
  );
`else
  modport master (
    output in_valid, code, f_flag, out_ready,
    input  in_ready, out_valid, data, en_flag, short_err
  );
  modport slave (
    input  in_valid, code, f_flag, out_ready,
    output in_ready, out_valid, data, en_flag, short_err
  );
`endif
endinterface

// File: rtl/fns_serial_decoder_weight_step.sv
// fns_weight_step: one combinational FNS step for a single TSV; zero latency, no flow control.
// Advances the Fibonacci pair only on healthy TSVs while data weights are still owed.
module fns_weight_step
  import fns_serial_decoder_pkg::*;
(
  input  logic [W_W-1:0]   i_a,
  input  logic [W_W-1:0]   i_b,
  input  logic             i_healthy,
  input  logic             i_code,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [W_W-1:0]   o_a,
  output logic [W_W-1:0]   o_b,
  output logic [W_W-1:0]   o_contrib,
  output logic             o_en
);
  logic [W_W:0]   w_sum;
  logic [W_W-1:0] w_w;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_w   = w_sum[W_W-1:0];

  // The pair freezes at (5,8) once all weights are issued, so the carry never sets
  always_comb assert (!w_sum[W_W]);

  assign o_en      = i_healthy && (i_cnt < CNT_W'(N_DATA));
  assign o_a       = o_en ? i_b : i_a;
  assign o_b       = o_en ? w_w : i_b;
  assign o_contrib = (o_en && i_code) ? w_w : '0;
endmodule

// File: rtl/fns_serial_decoder.sv
// fns_serial_decoder: walks 9 TSVs LSB-first, one per cycle; out_valid 10 cycles after accept, held until out_ready.
// FNS_CAC_CHECK_EN adds code_err for a "11" pair across consecutive enabled TSVs.
module fns_serial_decoder
  import fns_serial_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fns_serial_decoder_if.slave  bus
);
  state_t            r_state;
  state_t            w_next;
  logic [N_TSV-1:0]  r_code;
  logic [N_TSV-1:0]  r_flag;
  logic [N_TSV-1:0]  r_en;
  logic [IDX_W-1:0]  r_idx;
  logic [W_W-1:0]    r_a;
  logic [W_W-1:0]    r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;

  logic              w_accept;
  logic              w_walk;
  logic              w_last;
  logic              w_bit;
  logic              w_en;
  logic [W_W-1:0]    w_a_nxt;
  logic [W_W-1:0]    w_b_nxt;
  logic [W_W-1:0]    w_contrib;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_walk   = (r_state == S_WALK);
  assign w_last   = (r_idx == IDX_W'(N_TSV - 1));
  assign w_bit    = r_code[r_idx];

  fns_weight_step u_step (
    .i_a       (r_a),
    .i_b       (r_b),
    .i_healthy (~r_flag[r_idx]),
    .i_code    (w_bit),
    .i_cnt     (r_cnt),
    .o_a       (w_a_nxt),
    .o_b       (w_b_nxt),
    .o_contrib (w_contrib),
    .o_en      (w_en)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_next = S_WALK;
      S_WALK:  if (w_last) w_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code <= '0;
      r_flag <= '0;
      r_en   <= '0;
      r_idx  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_code <= bus.code;
      r_flag <= bus.f_flag;
      r_en   <= '0;
      r_idx  <= '0;
      r_a    <= FIB_A0;
      r_b    <= FIB_B0;
      r_cnt  <= '0;
      r_acc  <= '0;
    end else if (w_walk) begin
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_acc        <= r_acc + DATA_W'(w_contrib);
      r_en[r_idx]  <= w_en;
      if (w_en)    r_cnt <= r_cnt + 1'b1;
      if (!w_last) r_idx <= r_idx + 1'b1;
    end
  end

`ifdef FNS_CAC_CHECK_EN
  logic r_prev;
  logic r_cerr;

  // Faulty and redundant TSVs are transparent: only enabled bits update r_prev
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_prev <= 1'b0;
      r_cerr <= 1'b0;
    end else if (w_walk && w_en) begin
      if (r_prev && w_bit) r_cerr <= 1'b1;
      r_prev <= w_bit;
    end
  end
`endif

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.data      = '0;
    bus.en_flag   = '0;
    bus.short_err = 1'b0;
`ifdef FNS_CAC_CHECK_EN
    bus.code_err  = 1'b0;
`endif
    case (r_state)
      S_IDLE: bus.in_ready = 1'b1;
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.data      = r_acc;
        bus.en_flag   = r_en;
        bus.short_err = (r_cnt < CNT_W'(N_DATA));
`ifdef FNS_CAC_CHECK_EN
        bus.code_err  = r_cerr;
`endif
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_fns_serial_decoder.sv
// Directed bench for fns_serial_decoder: Fibonacci-table model + per-cycle output compare + literal pins.
module tb_fns_serial_decoder;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  typedef struct {
    logic [4:0] data;
    logic [8:0] en;
    logic       short_e;
    logic       cerr;
  } exp_t;

  exp_t exp_q[$];

  fns_serial_decoder_if bus();

  fns_serial_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // First five healthy TSVs take weights 1,2,3,5,8 in order; everything else is ignored
  function automatic exp_t model(input logic [8:0] c, input logic [8:0] f);
    exp_t e;
    int   fib [5];
    int   k;
    int   sum;
    logic prev;
    fib    = '{1, 2, 3, 5, 8};
    k      = 0;
    sum    = 0;
    prev   = 1'b0;
    e.en   = '0;
    e.cerr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!f[i] && k < 5) begin
        e.en[i] = 1'b1;
        if (c[i]) begin
          sum += fib[k];
          if (prev) e.cerr = 1'b1;
        end
        prev = c[i];
        k++;
      end
    end
    e.data    = 5'(sum);
    e.short_e = (k < 5);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected out_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        chk("data", {27'd0, bus.data}, {27'd0, exp_q[0].data});
        chk("en_flag", {23'd0, bus.en_flag}, {23'd0, exp_q[0].en});
        chk("short_err", {31'd0, bus.short_err}, {31'd0, exp_q[0].short_e});
`ifdef FNS_CAC_CHECK_EN
        chk("code_err", {31'd0, bus.code_err}, {31'd0, exp_q[0].cerr});
`endif
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Presents a word, waits for acceptance, then returns on the first out_valid cycle
  task automatic send(input logic [8:0] c, input logic [8:0] f);
    int n;
    int lat;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.code     = c;
    bus.f_flag   = f;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    chk("accept", {31'd0, bus.in_ready}, 32'd1);
    exp_q.push_back(model(c, f));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.code     = 9'($urandom);
    bus.f_flag   = 9'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    chk("latency", lat, 10);
  endtask

  initial begin
    logic [4:0] d0;
    logic [8:0] e0;
    n_pass        = 0;
    n_total       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.code      = '0;
    bus.f_flag    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset data", {27'd0, bus.data}, 32'd0);
    chk("reset en_flag", {23'd0, bus.en_flag}, 32'd0);
    chk("reset short_err", {31'd0, bus.short_err}, 32'd0);

    send(9'b0_0001_0101, 9'h000);
    chk("t1 data", {27'd0, bus.data}, 32'd12);
    chk("t1 en_flag", {23'd0, bus.en_flag}, 32'h01F);
    chk("t1 short_err", {31'd0, bus.short_err}, 32'd0);

    send(9'b0_0010_0001, 9'b0_0000_0010);
    chk("t2 data", {27'd0, bus.data}, 32'd9);
    chk("t2 en_flag", {23'd0, bus.en_flag}, 32'h03D);

    send(9'h1FF, 9'b1_1111_0000);
    chk("t3 data", {27'd0, bus.data}, 32'd11);
    chk("t3 en_flag", {23'd0, bus.en_flag}, 32'h00F);
    chk("t3 short_err", {31'd0, bus.short_err}, 32'd1);

    send(9'h1FF, 9'h1FF);
    chk("allfault data", {27'd0, bus.data}, 32'd0);
    chk("allfault en_flag", {23'd0, bus.en_flag}, 32'd0);
    chk("allfault short_err", {31'd0, bus.short_err}, 32'd1);

    send(9'h1FF, 9'h000);
    chk("max data", {27'd0, bus.data}, 32'd19);

    send(9'b0_1010_1010, 9'b1_0101_0101);
    chk("alt data", {27'd0, bus.data}, 32'd11);
    chk("alt en_flag", {23'd0, bus.en_flag}, 32'h0AA);

    // Backpressure: hold DONE for five cycles while poking in_valid
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(9'b1_0110_0110, 9'b0_0000_1000);
    d0 = bus.data;
    e0 = bus.en_flag;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = (i % 2 == 1);
      bus.code     = 9'h1FF;
      bus.f_flag   = 9'h000;
      @(negedge clk);
      chk("hold data", {27'd0, bus.data}, {27'd0, d0});
      chk("hold en_flag", {23'd0, bus.en_flag}, {23'd0, e0});
      chk("hold in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("hold out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("handshake in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    chk("post-handshake in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("post-handshake out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (12) @(negedge clk);
    chk("no ghost word", {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of the walk, at idx 4
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.code     = 9'h1FF;
    bus.f_flag   = 9'h000;
    @(negedge clk);
    chk("rst-word accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midwalk rst in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midwalk rst out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midwalk rst data", {27'd0, bus.data}, 32'd0);
    repeat (12) @(negedge clk);
    chk("abandoned word silent", {31'd0, bus.out_valid}, 32'd0);
    send(9'b0_0010_0001, 9'b0_0000_0010);
    chk("after rst data", {27'd0, bus.data}, 32'd9);

`ifdef FNS_CAC_CHECK_EN
    send(9'b0_0000_0101, 9'b0_0000_0010);
    chk("cac adjacent code_err", {31'd0, bus.code_err}, 32'd1);
    chk("cac adjacent data", {27'd0, bus.data}, 32'd3);
    send(9'b0_0000_1001, 9'b0_0000_0010);
    chk("cac clean code_err", {31'd0, bus.code_err}, 32'd0);
    chk("cac clean data", {27'd0, bus.data}, 32'd4);
`endif

    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    chk("words outstanding", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fns_serial_decoder.md
Name: fns_serial_decoder

Overview:
- Receiver-side counterpart of the Fibonacci-numeral-system (FNS) weight/adder chain used on the 9-TSV link (x=5 data, y=4 redundant).
- Accepts one received 9-bit TSV codeword plus the per-TSV fault flags.
- Walks the TSVs LSB-first, one per cycle, regenerating the FNS weights on the fly while skipping faulty TSVs. Accumulates the weights of set, enabled bits into a binary word.
- Sits after the TSV receive flops, ahead of the core datapath.

Parameters:
- N_TSV, 9, total TSVs (x+y).
- N_DATA, 5, healthy TSVs that carry weights; later healthy TSVs are redundant.
- W_W, 4, weight register width (holds F up to 8).
- DATA_W, 5, decoded output width (max sum 1+2+3+5+8=19).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  codeword/flags valid
- in_ready  out  1  decoder can accept
- code  in  N_TSV  received TSV bits, bit0 = first TSV
- f_flag  in  N_TSV  fault flags, bit0 = first TSV
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- data  out  DATA_W  decoded binary value
- en_flag  out  N_TSV  TSVs that carried a weight for this word
- short_err  out  1  fewer than N_DATA healthy TSVs; data unreliable

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, in_ready=1, out_valid=0, data=0, en_flag=0, short_err=0, all internal registers cleared. rst has priority over every other event.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch code and f_flag, set idx=0, a=0, b=1, acc=0, cnt=0, and go to WALK.
  - WALK: in_ready=0. Each cycle handles TSV idx:
    - If f_flag[idx]=0 and cnt<N_DATA: w=a+b, a<=b, b<=w, cnt<=cnt+1, en[idx]<=1, and acc<=acc+(code[idx]?w:0).
    - Otherwise: a, b, acc and cnt are unchanged and en[idx]<=0.
    - When idx=N_TSV-1, go to DONE; otherwise idx<=idx+1.
  - DONE: drive out_valid=1 with data=acc, en_flag=en, and short_err=(cnt<N_DATA). Outputs hold stable until out_ready=1. On that handshake, go to IDLE and drop out_valid.
- Weight sequence over healthy TSVs is 1,2,3,5,8.
- Latency: the accept edge plus N_TSV WALK cycles, so out_valid rises 10 cycles after acceptance with default parameters.
- Throughput: one word per N_TSV+2 cycles at best.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE. In DONE with out_ready=1, in_ready stays 0 that cycle; a new word is accepted the next cycle at the earliest.
- Set bits on faulty or redundant TSVs contribute nothing and raise no flag (redundant lines may toggle freely).
- Width rules: acc is DATA_W bits and cannot overflow for legal parameters. The adder for w is W_W+1 bits internally and truncated to W_W.
- All f_flag=1: cnt=0, data=0, en_flag=0, short_err=1.
- rst asserted during WALK or DONE abandons the word with no output.

Optional Feature:
- Macro: FNS_CAC_CHECK_EN.
- Defined:
  - Adds output code_err (1 bit), valid with out_valid.
  - code_err is set if two consecutive enabled TSVs, ignoring skipped faulty TSVs between them, both carry 1. This is the forbidden FNS "11" pattern and flags a crosstalk-avoidance violation.
  - Needs one extra register holding the previous enabled bit. code_err resets to 0.
  - data is still the plain weighted sum.
- Undefined: no code_err port and no check logic; everything else is identical.

Decomposition:
- Shared package: N_TSV, N_DATA, W_W, DATA_W defaults; state encoding IDLE/WALK/DONE; Fibonacci seed constants (a=0, b=1).
- One sub-module, fns_weight_step:
  - Inputs a, b, healthy, code bit, cnt.
  - Outputs next a, b, weight contribution, enable bit.
  - Pure combinational; instantiated once and time-multiplexed by the FSM.

Test Plan:
- f_flag=0, code=9'b0_0001_0101 -> data=12 (1+3+8), en_flag=9'h01F, short_err=0, out_valid 10 cycles after accept.
- f_flag=9'b0_0000_0010, code=9'b0_0010_0001 -> enabled TSVs 0,2,3,4,5 with weights 1,2,3,5,8; data=1+8=9, en_flag=9'b0_0011_1101.
- f_flag=9'b1_1111_0000, code=9'h1FF -> cnt=4, data=11, en_flag=9'h00F, short_err=1.
- out_ready held 0 for 5 cycles in DONE -> data/en_flag stable, in_ready=0, in_valid pulses ignored; first accept on the cycle after out_ready=1.
- rst pulsed at WALK idx=4 -> next cycle in_ready=1, out_valid=0, data=0; a following clean word decodes correctly.
- With FNS_CAC_CHECK_EN, f_flag=9'b0_0000_0010, code=9'b0_0000_0101 -> TSVs 0 and 2 are adjacent enabled bits, so code_err=1 and data=3. With code=9'b0_0000_1001 -> code_err=0.
